vga_pattern_gen: RTL
====================

Name: vga_pattern_gen

Overview:
- Parametrised next-generation VGA test-pattern and blink engine.
- Sits between the hvsync timing generator and the VGA DAC pins.
- Takes the pixel counters, display-area flag and raw syncs; produces registered RGB plus re-aligned syncs.
- Adds selectable patterns, multi-bit colour depth, frame-synchronous control updates and parametrised blink timing.

Parameters:
- COLOR_BITS, 1, bits per colour channel; a channel is "on" when all its bits are 1.
- X_W, 10, width of counter_x and counter_y.
- H_ACTIVE, 640, visible width in pixels; must be divisible by 8.
- CNT_W, 25, blink counter width.
- BLINK_ON, 4000000, count at which the blink phase turns on.
- BLINK_PERIOD, 8000000, blink period in clk cycles; requires BLINK_ON < BLINK_PERIOD <= 2^CNT_W.
- SQ_LOG2, 5, checkerboard square size is 2^SQ_LOG2 pixels.
- SYNC_ACT_LOW, 1, polarity of hsync/vsync (1 = active low).

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst_n  in  1  asynchronous active-low reset.
- counter_x  in  X_W  horizontal pixel counter from the timing generator.
- counter_y  in  X_W  vertical line counter from the timing generator.
- in_display_area  in  1  high in the visible region.
- hsync_in  in  1  raw hsync from the timing generator.
- vsync_in  in  1  raw vsync from the timing generator.
- mode  in  2  pattern select, asynchronous switch input.
- colour_sel  in  3  {b,g,r} colour enables, active high, asynchronous switch input.
- pixel  out  3*COLOR_BITS  {B,G,R}; R in the low COLOR_BITS bits.
- hsync_out  out  1  hsync delayed to align with pixel.
- vsync_out  out  1  vsync delayed to align with pixel.
- frame_tick  out  1  one-cycle pulse when new control settings take effect.

Behaviour:
- Reset (async assert, sync release), all values forced:
  - pixel = 0.
  - hsync_out and vsync_out at their inactive level.
  - frame_tick = 0; blink counter = 0.
  - active mode = 0; active colour = 3'b000.
  - synchronizer flops = 0.
- Control inputs: mode and colour_sel each pass through a 2-flop synchronizer.
- Frame-boundary update:
  - Detect the vsync_in assertion edge from a registered copy of vsync_in.
  - On the cycle after the edge, copy the synchronized mode and colour into the active registers and pulse frame_tick for 1 cycle.
  - Control changes never take effect mid-frame.
- Blink counter:
  - Free-running, increments each clk and wraps from BLINK_PERIOD-1 to 0.
  - blink_on = (cnt >= BLINK_ON).
- Pipeline, fixed latency 2 clk from counter_x/counter_y/in_display_area/hsync_in/vsync_in to pixel/hsync_out/vsync_out:
  - Stage 1 registers x, y, area and syncs.
  - Stage 2 computes colour and masks it.
- Modes, with an "on" channel driven as all ones and an "off" channel as all zeros:
  - 0 SOLID: channel on iff its active colour bit is set.
  - 1 BLINK: as SOLID AND blink_on; output is black for cnt < BLINK_ON.
  - 2 BARS:
    - bar = x / (H_ACTIVE/8), clamped to 7 when x >= H_ACTIVE.
    - Channels {b,g,r} = bar[2:0]; active colour is ignored.
    - The divide is implemented as a constant comparator chain; no divider.
  - 3 CHECKER:
    - cell = x[SQ_LOG2] ^ y[SQ_LOG2].
    - cell = 0 gives the active colour; cell = 1 gives its bitwise inverse.
- pixel is 0 whenever the stage-1 area flag is 0, in every mode.
- Simultaneous events:
  - A vsync edge coinciding with a control change latches the synchronizer output of that cycle.
  - The blink wrap is independent of frame updates.
- Reset mid-frame: outputs are forced immediately. After release, the mode stays 0 with colour 000 (black) until the next vsync edge.

Decomposition:
- Package vga_pkg:
  - Mode constants MODE_SOLID=0, MODE_BLINK=1, MODE_BARS=2, MODE_CHECKER=3.
  - Default timing constants: H_ACTIVE, V_ACTIVE.
  - The pixel-channel index constants R=0, G=1, B=2.
- Sub-module vga_sync_ff: a 2-flop synchronizer, parametrised width, async active-low reset, instantiated once for {mode, colour_sel}.

Test Plan (sim params: BLINK_ON=4, BLINK_PERIOD=8, COLOR_BITS=2, SQ_LOG2=2):
- Reset:
  - Stimulus: rst_n=0 mid-stream.
  - Required: pixel=0, hsync_out=vsync_out=1 and frame_tick=0 in the same cycle.
  - After release: pixel stays 0 until the first vsync edge, then frame_tick pulses once.
- SOLID latency and masking:
  - Stimulus: mode=0, colour_sel=3'b101, then a vsync edge, then area=1.
  - Required: pixel=6'b110011 exactly 2 clk after the input.
  - Required: area=0 gives pixel=0 at the same 2-clk latency.
  - Required: sync outputs are delayed by 2 clk.
- BLINK:
  - Stimulus: mode=1, colour 3'b111, area held 1.
  - Required: pixel=0 for 4 cycles, then 6'b111111 for 4 cycles, repeating with period 8.
  - Required: counter wraps 7->0.
- BARS:
  - Stimulus: x=0, 79, 80, 639, 700.
  - Required: bar 0, 0, 1, 7, 7 respectively.
  - Required: x=80 gives pixel {B,G,R}=00,00,11.
- CHECKER:
  - Stimulus: colour 3'b001; (x,y)=(0,0), then (4,0), then (4,4).
  - Required: pixel=000011, then 111100, then 000011.
- Frame-synchronous control:
  - Stimulus: change mode 0->2 mid-frame.
  - Required: output pattern unchanged until 1 clk after the vsync edge, when frame_tick pulses and bars appear.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA test-pattern engine.
//   mode_e      - pattern select encoding used by the active-mode register
//   H_ACTIVE    - default visible width, V_ACTIVE - default visible height
//   R, G, B     - channel index within the {B,G,R} pixel word
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_BARS    = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_e;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam int R = 0;
    localparam int G = 1;
    localparam int B = 2;

endpackage

// File: rtl/vga_sync_ff.sv
// vga_sync_ff: two-flop synchronizer for slow asynchronous switch inputs.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flop stages
//   i_d   - asynchronous input bus (bits are independent slow levels)
//   o_q   - synchronized copy of i_d, two clk cycles later
module vga_sync_ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern and blink engine between the sync timing
// generator and the VGA DAC.
//   clk, rst_n           - pixel clock, asynchronous active-low reset
//   counter_x/counter_y  - pixel / line counters from the timing generator
//   in_display_area      - visible-region flag
//   hsync_in/vsync_in    - raw syncs from the timing generator
//   mode, colour_sel     - asynchronous switches: pattern and {b,g,r} enables
//   pixel                - registered {B,G,R}, COLOR_BITS per channel
//   hsync_out/vsync_out  - syncs delayed to line up with pixel
//   frame_tick           - one-cycle pulse when new switch settings take effect
module vga_pattern_gen import vga_pkg::*; #(
    parameter int COLOR_BITS   = 1,
    parameter int X_W          = 10,
    parameter int H_ACTIVE     = vga_pkg::H_ACTIVE,
    parameter int CNT_W        = 25,
    parameter int BLINK_ON     = 4000000,
    parameter int BLINK_PERIOD = 8000000,
    parameter int SQ_LOG2      = 5,
    parameter int SYNC_ACT_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [X_W-1:0]            counter_x,
    input  logic [X_W-1:0]            counter_y,
    input  logic                      in_display_area,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic [1:0]                mode,
    input  logic [2:0]                colour_sel,
    output logic [3*COLOR_BITS-1:0]   pixel,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      frame_tick
);

    localparam int   PW        = 3 * COLOR_BITS;
    localparam int   BAR_W     = H_ACTIVE / 8;
    localparam logic SYNC_IDLE = (SYNC_ACT_LOW != 0);

    // bar = x / BAR_W as a chain of constant compares; x >= H_ACTIVE lands on 7
    function automatic logic [2:0] bar_index(input logic [X_W-1:0] x);
        logic [2:0] b;
        b = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x >= X_W'(k * BAR_W)) b = 3'(k);
        end
        return b;
    endfunction

    // each enabled channel is driven all ones, a disabled one all zeros
    function automatic logic [PW-1:0] expand(input logic [2:0] en);
        logic [PW-1:0] p;
        p = '0;
        p[R*COLOR_BITS +: COLOR_BITS] = {COLOR_BITS{en[R]}};
        p[G*COLOR_BITS +: COLOR_BITS] = {COLOR_BITS{en[G]}};
        p[B*COLOR_BITS +: COLOR_BITS] = {COLOR_BITS{en[B]}};
        return p;
    endfunction

    logic [4:0]       w_ctl_sync;
    logic             w_vs_edge;
    logic             w_blink_on;
    logic [2:0]       w_bar;
    logic             w_cell;
    logic [2:0]       w_en;
    logic             w_unused_y;

    logic             r_vs_d;
    mode_e            r_mode;
    logic [2:0]       r_col;
    logic             r_tick;
    logic [CNT_W-1:0] r_cnt;

    logic [X_W-1:0]   r_x_p1;
    logic             r_ycell_p1;
    logic             r_area_p1;
    logic             r_hs_p1;
    logic             r_vs_p1;

    logic [PW-1:0]    r_pixel_p2;
    logic             r_hs_p2;
    logic             r_vs_p2;

    vga_sync_ff #(.WIDTH(5)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   ({mode, colour_sel}),
        .o_q   (w_ctl_sync)
    );

    // only the square-select bit of y matters to the patterns
    assign w_unused_y = &{1'b0, counter_y};

    // assertion edge of raw vsync: idle level last cycle, active level now
    assign w_vs_edge = (r_vs_d == SYNC_IDLE) && (vsync_in != SYNC_IDLE);

    // switch settings are only adopted at a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d <= SYNC_IDLE;
            r_mode <= MODE_SOLID;
            r_col  <= 3'b000;
            r_tick <= 1'b0;
        end else begin
            r_vs_d <= vsync_in;
            r_tick <= w_vs_edge;
            if (w_vs_edge) begin
                r_mode <= mode_e'(w_ctl_sync[4:3]);
                r_col  <= w_ctl_sync[2:0];
            end
        end
    end

    // free-running blink counter, independent of frame updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(BLINK_PERIOD - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_blink_on = (r_cnt >= CNT_W'(BLINK_ON));

    // ---- stage 1: register position, area and syncs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_p1     <= '0;
            r_ycell_p1 <= 1'b0;
            r_area_p1  <= 1'b0;
            r_hs_p1    <= SYNC_IDLE;
            r_vs_p1    <= SYNC_IDLE;
        end else begin
            r_x_p1     <= counter_x;
            r_ycell_p1 <= counter_y[SQ_LOG2];
            r_area_p1  <= in_display_area;
            r_hs_p1    <= hsync_in;
            r_vs_p1    <= vsync_in;
        end
    end

    assign w_bar  = bar_index(r_x_p1);
    assign w_cell = r_x_p1[SQ_LOG2] ^ r_ycell_p1;

    always_comb begin
        w_en = r_col;
        case (r_mode)
            MODE_SOLID:   w_en = r_col;
            MODE_BLINK:   w_en = w_blink_on ? r_col : 3'b000;
            MODE_BARS:    w_en = w_bar;
            MODE_CHECKER: w_en = w_cell ? ~r_col : r_col;
            default:      w_en = r_col;
        endcase
    end

    // ---- stage 2: colour, blanking mask and aligned syncs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel_p2 <= '0;
            r_hs_p2    <= SYNC_IDLE;
            r_vs_p2    <= SYNC_IDLE;
        end else begin
            r_pixel_p2 <= r_area_p1 ? expand(w_en) : '0;
            r_hs_p2    <= r_hs_p1;
            r_vs_p2    <= r_vs_p1;
        end
    end

    assign pixel      = r_pixel_p2;
    assign hsync_out  = r_hs_p2;
    assign vsync_out  = r_vs_p2;
    assign frame_tick = r_tick;

endmodule
